// File: rtl/sgd_loss_pkg.sv
// Shared definitions for the loss-stage read scheduler.
// - state_e     : scheduler FSM states
// - *_DEF       : default sizing; CREDITS covers adder-tree depth plus loss pipe depth
// - cnt_width() : bits needed to hold 0..max_val
package sgd_loss_pkg;

    localparam int unsigned ENGINE_NUM_DEF   = 8;
    // One adder-tree level per doubling of the engine count.
    localparam int unsigned ENGINE_NUM_WIDTH = $clog2(ENGINE_NUM_DEF);
    localparam int unsigned LOSS_PIPE_DEPTH  = 13;
    localparam int unsigned CREDITS_DEF      = ENGINE_NUM_WIDTH + LOSS_PIPE_DEPTH;
    localparam int unsigned SKEW_MAX_DEF     = 4 * CREDITS_DEF;
    localparam int unsigned CNT_W_DEF        = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sgd_loss_rd_sched_if.sv
// Handshake/status bundle of the loss-stage read scheduler.
// master: batch control, FIFO empty flags and credit returns (drives the scheduler)
// slave : the scheduler (drives read enables, busy/done, issued count, skew error)
// With SGD_LOSS_RD_PERF_EN defined, stall_data_cnt/stall_credit_cnt are added.
interface sgd_loss_rd_sched_if #(
    parameter int unsigned ENGINE_NUM = 8,
    parameter int unsigned CNT_W      = 32
);
    logic                  start;
    logic [CNT_W-1:0]      num_samples;
    logic [ENGINE_NUM-1:0] a_empty;
    logic                  b_empty;
    logic [ENGINE_NUM-1:0] a_rd_en;
    logic                  b_rd_en;
    logic                  credit_ret;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      issued_cnt;
    logic                  err_skew;
`ifdef SGD_LOSS_RD_PERF_EN
    logic [CNT_W-1:0]      stall_data_cnt;
    logic [CNT_W-1:0]      stall_credit_cnt;
`endif

    modport master (
        output start, num_samples, a_empty, b_empty, credit_ret,
        input  a_rd_en, b_rd_en, busy, done, issued_cnt, err_skew
`ifdef SGD_LOSS_RD_PERF_EN
        , input stall_data_cnt, stall_credit_cnt
`endif
    );

    modport slave (
        input  start, num_samples, a_empty, b_empty, credit_ret,
        output a_rd_en, b_rd_en, busy, done, issued_cnt, err_skew
`ifdef SGD_LOSS_RD_PERF_EN
        , output stall_data_cnt, stall_credit_cnt
`endif
    );

endinterface

// File: rtl/sgd_credit_counter.sv
// Up/down credit counter for downstream result slots.
// Ports: clk, rst_n (async, resets to CREDITS), inc (slot returned), dec (slot taken),
//        count (free slots), ovf (return while already full; ignored).
module sgd_credit_counter
    import sgd_loss_pkg::*;
#(
    parameter int unsigned CREDITS = CREDITS_DEF,
    localparam int unsigned W      = cnt_width(CREDITS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf
);

    logic [W-1:0] count_q, count_d;
    logic         full;

    assign full  = (count_q == W'(CREDITS));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        ovf     = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (full) ovf = 1'b1;
                else      count_d = count_q + W'(1);
            end
            2'b01: begin
                if (count_q != '0) count_d = count_q - W'(1);
            end
            default: count_d = count_q;   // idle, or inc and dec cancel
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= W'(CREDITS);
        else        count_q <= count_d;
    end

endmodule

// File: rtl/sgd_loss_rd_sched.sv
// Lock-step read scheduler for the loss stage: reads all dot-product FIFOs and the b FIFO
// together when all hold data and a downstream slot is free; counts issued samples,
// pulses done once every in-flight result has returned, and flags engine skew.
// Ports: clk, rst_n (async active-low), bus (sgd_loss_rd_sched_if.slave).
// Optional: SGD_LOSS_RD_PERF_EN adds stall_data_cnt / stall_credit_cnt.
module sgd_loss_rd_sched
    import sgd_loss_pkg::*;
#(
    parameter int unsigned ENGINE_NUM = ENGINE_NUM_DEF,
    parameter int unsigned CREDITS    = CREDITS_DEF,
    parameter int unsigned SKEW_MAX   = SKEW_MAX_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    sgd_loss_rd_sched_if.slave bus
);

    localparam int unsigned CRED_W = cnt_width(CREDITS);
    localparam int unsigned SKEW_W = cnt_width(SKEW_MAX);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [SKEW_W-1:0]  skew_q, skew_d;
    logic               err_q, err_d;
    logic [CRED_W-1:0]  cred_count;
    logic               cred_ovf;
    logic               data_ok, partial, issue;

    sgd_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.credit_ret),
        .dec   (issue),
        .count (cred_count),
        .ovf   (cred_ovf)
    );

    assign data_ok = ~|bus.a_empty & ~bus.b_empty;
    // Some engines have data, some do not.
    assign partial = |bus.a_empty & ~&bus.a_empty;
    // Zero-latency from flags; state_q resets asynchronously, so reads drop with rst_n.
    assign issue   = (state_q == StRun) & data_ok & (cred_count != '0) & (issued_q < n_q);

    assign bus.a_rd_en    = {ENGINE_NUM{issue}};
    assign bus.b_rd_en    = issue;
    assign bus.busy       = (state_q == StRun) | (state_q == StDrain);
    assign bus.done       = (state_q == StDone);
    assign bus.issued_cnt = issued_q;
    assign bus.err_skew   = err_q;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        issued_d = issued_q;
        skew_d   = '0;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    n_d      = bus.num_samples;
                    issued_d = '0;
                    err_d    = 1'b0;
                    state_d  = (bus.num_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue) issued_d = issued_q + CNT_W'(1);
                if (partial) begin
                    skew_d = skew_q;
                    if (skew_q < SKEW_W'(SKEW_MAX)) begin
                        skew_d = skew_q + SKEW_W'(1);
                        if (skew_d == SKEW_W'(SKEW_MAX)) err_d = 1'b1;
                    end
                end
                if (issued_d == n_q) state_d = StDrain;
            end
            StDrain: begin
                if (cred_count == CRED_W'(CREDITS)) state_d = StDone;
            end
            StDone: state_d = StIdle;
        endcase
        // A return into a full pool means results arrived that were never issued.
        if (cred_ovf) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            n_q      <= '0;
            issued_q <= '0;
            skew_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            issued_q <= issued_d;
            skew_q   <= skew_d;
            err_q    <= err_d;
        end
    end

`ifdef SGD_LOSS_RD_PERF_EN
    logic [CNT_W-1:0] stall_data_q, stall_credit_q;
    logic             start_ok;

    assign start_ok             = (state_q == StIdle) & bus.start;
    assign bus.stall_data_cnt   = stall_data_q;
    assign bus.stall_credit_cnt = stall_credit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_data_q   <= '0;
            stall_credit_q <= '0;
        end else if (start_ok) begin
            stall_data_q   <= '0;
            stall_credit_q <= '0;
        end else if (state_q == StRun) begin
            if (!data_ok && stall_data_q != '1) stall_data_q <= stall_data_q + CNT_W'(1);
            if (data_ok && cred_count == '0 && stall_credit_q != '1) begin
                stall_credit_q <= stall_credit_q + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sgd_loss_rd_sched.sv
module tb_sgd_loss_rd_sched;

    localparam int unsigned ENGINE_NUM = 8;
    localparam int unsigned CREDITS    = 16;
    localparam int unsigned CNT_W      = 32;

    typedef struct {
        logic [31:0] n;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    sgd_loss_rd_sched_if #(.ENGINE_NUM(ENGINE_NUM), .CNT_W(CNT_W)) bus_if ();

    sgd_loss_rd_sched #(
        .ENGINE_NUM (ENGINE_NUM),
        .CREDITS    (CREDITS),
        .SKEW_MAX   (64),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    int          due_q[$];
    int          cyc = 0;
    int          hold = 0;
    int          rel_cnt = 0;
    bit          loop_en = 0;
    int          batch_issues = 0;
    int          first_iss_cyc = 0;
    int          last_iss_cyc = 0;
    bit          done_seen = 0;
    logic        done_prev = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor + credit-return model: results come back 5 cycles after issue in loop mode,
    // otherwise they are held until the bench releases them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.b_rd_en || bus_if.a_rd_en != '0) begin
                check_eq("rd_en_lockstep", 64'(bus_if.a_rd_en), 64'({ENGINE_NUM{bus_if.b_rd_en}}));
            end
            if (bus_if.b_rd_en) begin
                if (batch_issues == 0) first_iss_cyc = cyc;
                last_iss_cyc = cyc;
                batch_issues++;
                if (loop_en) due_q.push_back(cyc + 5);
                else         hold++;
            end
            bus_if.credit_ret = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                bus_if.credit_ret = 1'b1;
            end else if (rel_cnt > 0 && hold > 0) begin
                rel_cnt--;
                hold--;
                bus_if.credit_ret = 1'b1;
            end
            if (bus_if.done) begin
                check_eq("done_single", 64'(done_prev), 64'(0));
                check_eq("sb_pending", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("sb_issued_cnt", 64'(bus_if.issued_cnt), 64'(e.n));
                    check_eq("sb_rd_pulses", 64'(batch_issues), 64'(e.n));
                    check_eq("sb_err_skew", 64'(bus_if.err_skew), 64'(e.err));
                end
                done_seen = 1'b1;
            end
            done_prev = bus_if.done;
        end
    end

    // Called #1 after a rising edge; leaves the bench #1 after the edge that samples start.
    task automatic start_batch(input logic [31:0] n, input bit accept, input bit exp_err);
        if (accept) begin
            exp_t e;
            e.n = n;
            e.err = exp_err;
            sb.push_back(e);
            batch_issues = 0;
            done_seen = 1'b0;
        end
        bus_if.num_samples = n;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && !done_seen; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check_eq(tag, 64'(done_seen), 64'(1));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] snap;
        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.num_samples = '0;
        bus_if.a_empty = '1;
        bus_if.b_empty = 1'b1;
        bus_if.credit_ret = 1'b0;
        step(3);
        check_eq("rst_a_rd_en", 64'(bus_if.a_rd_en), 64'(0));
        rst_n = 1'b1;
        step(1);
        check_eq("rst_busy", 64'(bus_if.busy), 64'(0));
        check_eq("rst_done", 64'(bus_if.done), 64'(0));
        check_eq("rst_issued", 64'(bus_if.issued_cnt), 64'(0));
        check_eq("rst_err", 64'(bus_if.err_skew), 64'(0));
        check_eq("rst_credits", 64'(u_dut.cred_count), 64'(CREDITS));

        // Nominal: 10 samples, credits loop back.
        loop_en = 1'b1;
        bus_if.a_empty = '0;
        bus_if.b_empty = 1'b0;
        start_batch(10, 1, 0);
        check_eq("nom_busy", 64'(bus_if.busy), 64'(1));
        wait_done("nom_done_timeout", 100);
        check_eq("nom_back_to_back", 64'(last_iss_cyc - first_iss_cyc), 64'(9));
        check_eq("nom_issued_hold", 64'(bus_if.issued_cnt), 64'(10));
        check_eq("nom_idle_busy", 64'(bus_if.busy), 64'(0));

        // Credit stall: no returns, so only CREDITS reads go out.
        loop_en = 1'b0;
        start_batch(20, 1, 0);
        step(40);
        check_eq("stall_issues", 64'(batch_issues), 64'(16));
        check_eq("stall_busy", 64'(bus_if.busy), 64'(1));
        check_eq("stall_credits", 64'(u_dut.cred_count), 64'(0));
        rel_cnt = 4;
        step(20);
        check_eq("stall_rel_issues", 64'(batch_issues), 64'(20));
        check_eq("stall_drain_busy", 64'(bus_if.busy), 64'(1));
        check_eq("stall_no_done", 64'(done_seen), 64'(0));
        rel_cnt = 16;
        wait_done("stall_done_timeout", 80);
        rel_cnt = 0;

        // Partial empty: engine 3 starved.
        loop_en = 1'b1;
        bus_if.a_empty = 8'b0000_1000;
        start_batch(5, 1, 1);
        step(30);
        check_eq("skew_30_err", 64'(bus_if.err_skew), 64'(0));
        check_eq("skew_no_reads", 64'(batch_issues), 64'(0));
        step(33);
        check_eq("skew_63_err", 64'(bus_if.err_skew), 64'(0));
        step(1);
        check_eq("skew_64_err", 64'(bus_if.err_skew), 64'(1));
        bus_if.a_empty = '0;
        wait_done("skew_done_timeout", 100);
        check_eq("skew_sticky", 64'(bus_if.err_skew), 64'(1));

        // Zero batch: straight to DONE, and start clears err_skew.
        start_batch(0, 1, 0);
        check_eq("zero_done", 64'(bus_if.done), 64'(1));
        check_eq("zero_err_clr", 64'(bus_if.err_skew), 64'(0));
        step(1);
        check_eq("zero_done_drop", 64'(bus_if.done), 64'(0));
        check_eq("zero_no_rd", 64'(batch_issues), 64'(0));
        check_eq("zero_issued", 64'(bus_if.issued_cnt), 64'(0));

        // Simultaneous issue and return at credits==1; start in RUN ignored.
        loop_en = 1'b0;
        start_batch(40, 1, 0);
        step(30);
        check_eq("simul_pre_credits", 64'(u_dut.cred_count), 64'(0));
        rel_cnt = 6;
        step(3);
        check_eq("simul_credit_hold", 64'(u_dut.cred_count), 64'(1));
        step(8);
        snap = bus_if.issued_cnt;
        check_eq("simul_issued", 64'(snap), 64'(22));
        start_batch(3, 0, 0);
        check_eq("ign_start_cnt", 64'(bus_if.issued_cnt), 64'(snap));
        check_eq("ign_start_busy", 64'(bus_if.busy), 64'(1));
        loop_en = 1'b1;
        rel_cnt = 1000;
        wait_done("simul_done_timeout", 300);
        rel_cnt = 0;

        // Async reset mid-RUN.
        start_batch(30, 1, 0);
        for (int i = 0; i < 50 && batch_issues < 5; i++) @(posedge clk);
        #3;
        check_eq("arst_pre_rd", 64'(bus_if.b_rd_en), 64'(1));
        rst_n = 1'b0;
        #1;
        check_eq("arst_a_rd_en", 64'(bus_if.a_rd_en), 64'(0));
        check_eq("arst_b_rd_en", 64'(bus_if.b_rd_en), 64'(0));
        check_eq("arst_busy", 64'(bus_if.busy), 64'(0));
        check_eq("arst_issued", 64'(bus_if.issued_cnt), 64'(0));
        void'(sb.pop_front());
        due_q.delete();
        hold = 0;
        bus_if.credit_ret = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check_eq("arst_credits", 64'(u_dut.cred_count), 64'(CREDITS));
        start_batch(8, 1, 0);
        wait_done("arst_rerun_timeout", 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
